pwm_audio_out: RTL and testbench



---
 rtl/pwm_audio_out.sv | 127 ++++++++++++
 tb/tb_pwm_audio_out.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_audio_out.sv
// PWM audio output stage: single-entry sample buffer, period-aligned duty update, underrun counting.
// Optional macro PWM_UNDERRUN_MIDSCALE_EN: an underrun loads midscale duty instead of holding it.
module pwm_audio_out #(
  parameter int WIDTH  = 8,
  parameter int UCNT_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic [WIDTH-1:0]  sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              pwm_out,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef PWM_UNDERRUN_MIDSCALE_EN
  localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  duty_q, duty_d;
  logic [WIDTH-1:0]  buf_q, buf_d;
  logic              full_q, full_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;
  logic              accept;
  logic              boundary;

  function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
    if (v == {UCNT_W{1'b1}}) return v;
    return v + {{(UCNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign sample_ready   = !full_q;
  assign accept         = sample_valid && !full_q;
  assign boundary       = (state_q == RUN) && (count_q == CNT_MAX);
  assign pwm_out        = (state_q == RUN) && (count_q < duty_q);
  assign underrun       = enable && boundary && !full_q && !sample_valid;
  assign underrun_count = ucnt_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    duty_d  = duty_q;
    buf_d   = buf_q;
    full_d  = full_q;
    ucnt_d  = ucnt_q;

    if (accept) begin
      buf_d  = sample;
      full_d = 1'b1;
    end

    if (!enable) begin
      state_d = IDLE;
      count_d = '0;
      duty_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = PRIME;
          count_d = '0;
        end
        PRIME: begin
          count_d = '0;
          if (full_q) begin
            duty_d  = buf_q;
            full_d  = 1'b0;
            state_d = RUN;
          end
        end
        RUN: begin
          count_d = count_q + CNT_ONE;
          if (boundary) begin
            if (full_q) begin
              duty_d = buf_q;
              full_d = 1'b0;
            end else if (sample_valid) begin
              // Bypass: the sample goes straight to duty and never occupies the buffer.
              duty_d = sample;
              full_d = 1'b0;
            end else begin
              ucnt_d = sat_inc(ucnt_q);
`ifdef PWM_UNDERRUN_MIDSCALE_EN
              duty_d = MIDSCALE;
`else
              duty_d = duty_q;
`endif
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      count_q <= '0;
      duty_q  <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      duty_q  <= duty_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      ucnt_q  <= ucnt_d;
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out: handshake, duty timing, underrun/bypass, disable and async reset.
module tb_pwm_audio_out;

  logic       clk;
  logic       nrst;
  logic       enable;
  logic [7:0] sample;
  logic       sample_valid;
  logic       sample_ready;
  logic       pwm_out;
  logic       underrun;
  logic [7:0] underrun_count;

  int tests = 0;
  int fails = 0;
  int exp_uc = 0;

  int   highs, urs, nrdy;
  logic pwm_last, ur_last;

`ifdef PWM_UNDERRUN_MIDSCALE_EN
  localparam int P2_HIGHS = 128;
`else
  localparam int P2_HIGHS = 64;
`endif

  pwm_audio_out #(.WIDTH(8), .UCNT_W(8)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .enable         (enable),
    .sample         (sample),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .pwm_out        (pwm_out),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge where count==0; returns at the negedge where the next period starts.
  task automatic run_period(input int push_at, input logic [7:0] val,
                            output int h, output int u, output int nr,
                            output logic p255, output logic u255);
    h = 0; u = 0; nr = 0; p255 = 1'bx; u255 = 1'bx;
    for (int i = 0; i < 256; i++) begin
      sample_valid = (i == push_at);
      if (i == push_at) sample = val;
      #1;
      h  += int'(pwm_out);
      u  += int'(underrun);
      nr += int'(!sample_ready);
      if (i == 255) begin
        p255 = pwm_out;
        u255 = underrun;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; enable = 1'b0; sample = 8'h00; sample_valid = 1'b0;
    #120;
    chk("reset_pwm",   pwm_out, 0);
    chk("reset_ur",    underrun, 0);
    chk("reset_ucnt",  underrun_count, 0);
    chk("reset_ready", sample_ready, 1);
    @(negedge clk); nrst = 1'b1;
    @(negedge clk);
    chk("idle_pwm", pwm_out, 0);

    // Start: enable and push 0x40 on the same edge.
    enable = 1'b1; sample_valid = 1'b1; sample = 8'h40;
    #1 chk("start_ready_before", sample_ready, 1);
    @(negedge clk);
    sample_valid = 1'b0;
    chk("prime_ready_low", sample_ready, 0);
    chk("prime_pwm_low", pwm_out, 0);
    @(negedge clk);
    chk("run_ready_back", sample_ready, 1);
    chk("run_count0_pwm", pwm_out, 1);

    // P1: duty 0x40, no new sample -> underrun at count 255.
    run_period(-1, 8'h00, highs, urs, nrdy, pwm_last, ur_last);
    exp_uc++;
    chk("p1_highs", highs, 64);
    chk("p1_ur_pulses", urs, 1);
    chk("p1_ur_at_255", ur_last, 1);
    chk("p1_ucnt", underrun_count, exp_uc);

    // P2: post-underrun duty, push 0x80 at count 10.
    run_period(10, 8'h80, highs, urs, nrdy, pwm_last, ur_last);
    chk("p2_highs", highs, P2_HIGHS);
    chk("p2_ur_pulses", urs, 0);
    chk("p2_not_ready", nrdy, 245);
    chk("p2_ucnt", underrun_count, exp_uc);

    // P3: duty 0x80, underrun at the end.
    run_period(-1, 8'h00, highs, urs, nrdy, pwm_last, ur_last);
    exp_uc++;
    chk("p3_highs", highs, 128);
    chk("p3_ur_pulses", urs, 1);
    chk("p3_ucnt", underrun_count, exp_uc);

    // P4: bypass, valid 0x20 presented exactly at count 255 with buffer empty.
    run_period(255, 8'h20, highs, urs, nrdy, pwm_last, ur_last);
    chk("p4_highs", highs, 128);
    chk("p4_ur_pulses", urs, 0);
    chk("p4_ucnt", underrun_count, exp_uc);

    // P5: duty 0x20 via bypass; push 0xFF.
    run_period(10, 8'hFF, highs, urs, nrdy, pwm_last, ur_last);
    chk("p5_highs", highs, 32);
    chk("p5_ur_pulses", urs, 0);
    chk("p5_ready_after_bypass", sample_ready, 1);

    // P6: duty 0xFF, single low cycle at count 255.
    run_period(-1, 8'h00, highs, urs, nrdy, pwm_last, ur_last);
    exp_uc++;
    chk("p6_highs", highs, 255);
    chk("p6_low_at_255", pwm_last, 0);
    chk("p6_ucnt", underrun_count, exp_uc);

    // Disable at count 100 with 0x10 buffered.
    for (int i = 0; i < 100; i++) begin
      sample_valid = (i == 5);
      sample = 8'h10;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("dis_pwm_before", pwm_out, 1);
    chk("dis_buf_full", sample_ready, 0);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_pwm_idle", pwm_out, 0);
    chk("dis_buf_kept", sample_ready, 0);
    repeat (3) @(negedge clk);
    chk("dis_pwm_still", pwm_out, 0);
    chk("dis_ucnt_kept", underrun_count, exp_uc);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_prime_pwm", pwm_out, 0);
    chk("reen_prime_full", sample_ready, 0);
    @(negedge clk);
    chk("reen_run_ready", sample_ready, 1);

    // P7: duty 0x10 from retained buffer.
    run_period(10, 8'h00, highs, urs, nrdy, pwm_last, ur_last);
    chk("p7_highs", highs, 16);
    chk("p7_ur_pulses", urs, 0);

    // P8/P9: duty 0x00 never high.
    run_period(10, 8'h00, highs, urs, nrdy, pwm_last, ur_last);
    chk("p8_highs", highs, 0);
    run_period(-1, 8'h00, highs, urs, nrdy, pwm_last, ur_last);
    exp_uc++;
    chk("p9_highs", highs, 0);
    chk("p9_ucnt", underrun_count, exp_uc);

    // Long starvation: counter saturates and the pulse keeps firing.
    for (int k = 0; k < 256; k++) begin
      run_period(-1, 8'h00, highs, urs, nrdy, pwm_last, ur_last);
      exp_uc = (exp_uc == 255) ? 255 : exp_uc + 1;
    end
    chk("sat_ucnt", underrun_count, exp_uc);
    chk("sat_ucnt_255", underrun_count, 255);
    chk("sat_pulse_still", urs, 1);

    // Async reset mid-cycle with a sample buffered.
    sample_valid = 1'b1; sample = 8'h33;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("pre_rst_full", sample_ready, 0);
    #20 nrst = 1'b0;
    #1;
    chk("arst_ucnt", underrun_count, 0);
    chk("arst_ready", sample_ready, 1);
    chk("arst_pwm", pwm_out, 0);
    chk("arst_ur", underrun, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", sample_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
